multi_counter_dev_io: RTL and testbench



---
 rtl/multi_counter_dev_io_pkg.sv | 31 +++
 rtl/multi_counter_dev_io_channel.sv | 131 +++++++++++++
 rtl/multi_counter_dev_io.sv | 114 +++++++++++
 tb/tb_multi_counter_dev_io.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_counter_dev_io_pkg.sv
// Shared definitions for the multi-channel timer/counter peripheral:
// register offsets, counter modes, CTRL bit positions and the bus address
// width helper.
package counter_pkg;

    // Register offsets within one channel's 4-word window.
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Counter modes; encoding 2'b11 is reserved and behaves as one-shot.
    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_SQUARE   = 2'd2
    } mode_e;

    // CTRL register bit positions.
    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_MODE_LSB     = 1;
    localparam int CTRL_IRQ_EN_BIT   = 3;
    localparam int CTRL_CHAIN_BIT    = 4;
    localparam int CTRL_PRESCALE_LSB = 8;

    // Address is {channel, reg}: channel field plus two register bits.
    function automatic int addr_width(input int channels);
        return ((channels > 1) ? $clog2(channels) : 0) + 2;
    endfunction

endpackage

// File: rtl/multi_counter_dev_io_channel.sv
// One down-counter channel: prescaler, counter, mode handling, pending flag,
// terminal-count pulse and square-wave output.
// Optional build macro COUNTER_CHAIN_EN: when defined, CTRL.chain selects the
// previous channel's terminal event (ext_tick) as this channel's tick source.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8,
    parameter bit CHAIN_OK   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_ctrl,
    input  logic             wr_load,
    input  logic             wr_status,
    input  logic [31:0]      wdata,
    input  logic             ext_tick,
    output logic             term_event,
    output logic [31:0]      ctrl_word,
    output logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_val,
    output logic             pend,
    output logic             irq_en,
    output logic             tc,
    output logic             sq
);

    logic                  enable;
    logic [1:0]            mode;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] psc;
    logic                  chain;
    logic                  psc_hit;
    logic                  tick_src;
    logic                  tick;
    logic                  wr_any;
    logic                  is_periodic;
    logic                  is_square;

`ifdef COUNTER_CHAIN_EN
    // Chain select bit, written with the rest of CTRL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       chain <= 1'b0;
        else if (wr_ctrl) chain <= wdata[CTRL_CHAIN_BIT];
    end
`else
    assign chain = 1'b0;
`endif

    // Tick qualification: any CTRL/LOAD write this cycle drops the tick, and
    // a zero COUNT or LOAD makes ticks inert.
    always_comb begin
        wr_any      = wr_ctrl | wr_load;
        is_periodic = (mode == MODE_PERIODIC);
        is_square   = (mode == MODE_SQUARE);
        psc_hit     = (psc == prescale);
        tick_src    = (CHAIN_OK && chain) ? ext_tick : psc_hit;
        tick        = enable & tick_src & ~wr_any &
                      (count_val != '0) & (load_val != '0);
        term_event  = tick & (count_val == WIDTH'(1));
    end

    // Prescaler: cleared by CTRL/LOAD writes, otherwise counts 0..prescale while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      psc <= '0;
        else if (wr_any) psc <= '0;
        else if (enable) psc <= psc_hit ? '0 : psc + 1'b1;
    end

    // CTRL fields; a one-shot terminal event clears enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable   <= 1'b0;
            mode     <= 2'd0;
            irq_en   <= 1'b0;
            prescale <= '0;
        end else if (wr_ctrl) begin
            enable   <= wdata[CTRL_EN_BIT];
            mode     <= wdata[CTRL_MODE_LSB +: 2];
            irq_en   <= wdata[CTRL_IRQ_EN_BIT];
            prescale <= wdata[CTRL_PRESCALE_LSB +: PRESCALE_W];
        end else if (term_event && !is_periodic && !is_square) begin
            enable   <= 1'b0;
        end
    end

    // LOAD and COUNT: a LOAD write sets both and wins over any tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_val  <= '0;
            count_val <= '0;
        end else if (wr_load) begin
            load_val  <= wdata[WIDTH-1:0];
            count_val <= wdata[WIDTH-1:0];
        end else if (term_event) begin
            count_val <= (is_periodic || is_square) ? load_val : '0;
        end else if (tick) begin
            count_val <= count_val - 1'b1;
        end
    end

    // Pending flag: terminal event sets, W1C clears, set wins on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      pend <= 1'b0;
        else if (term_event)             pend <= 1'b1;
        else if (wr_status && wdata[0])  pend <= 1'b0;
    end

    // Terminal-count pulse and square-wave toggle follow the event by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc <= 1'b0;
            sq <= 1'b0;
        end else begin
            tc <= term_event;
            if (term_event && is_square) sq <= ~sq;
        end
    end

    // CTRL read-back image.
    always_comb begin
        ctrl_word                                         = '0;
        ctrl_word[CTRL_EN_BIT]                            = enable;
        ctrl_word[CTRL_MODE_LSB +: 2]                     = mode;
        ctrl_word[CTRL_IRQ_EN_BIT]                        = irq_en;
        ctrl_word[CTRL_CHAIN_BIT]                         = chain;
        ctrl_word[CTRL_PRESCALE_LSB +: PRESCALE_W]        = prescale;
    end

endmodule

// File: rtl/multi_counter_dev_io.sv
// Multi-channel timer/counter peripheral on the MIO bus: address decode,
// registered read mux, registered interrupt OR and CHANNELS counter channels.
// Optional build macro COUNTER_CHAIN_EN enables cascading of channel i from
// channel i-1's terminal event.
// Bus protocol: counter_we is a single-cycle write strobe qualified with
// counter_addr/counter_val; writes are always accepted (no ready). Reads have
// no strobe: counter_rdata shows the register addressed in the previous cycle.
module multi_counter_dev_io
    import counter_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            counter_we,
    input  logic [addr_width(CHANNELS)-1:0] counter_addr,
    input  logic [31:0]                     counter_val,
    output logic [31:0]                     counter_rdata,
    output logic                            counter_irq,
    output logic [CHANNELS-1:0]             counter_tc,
    output logic [CHANNELS-1:0]             counter_sq
);

    logic [31:0]         ctrl_words [CHANNELS];
    logic [WIDTH-1:0]    load_vals  [CHANNELS];
    logic [WIDTH-1:0]    count_vals [CHANNELS];
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] irq_en;
    logic [CHANNELS-1:0] term_events;
    logic [CHANNELS-1:0] ext_ticks;
    logic [CHANNELS-1:0] wr_ctrl;
    logic [CHANNELS-1:0] wr_load;
    logic [CHANNELS-1:0] wr_status;
    logic [31:0]         rd_next;
    logic [1:0]          reg_sel;
    int                  chan_sel;
    logic                unused_last_event;

    // The last channel's terminal event has no successor to feed.
    assign unused_last_event = term_events[CHANNELS-1];

    // Split the address into channel and register fields.
    always_comb begin
        chan_sel = int'(counter_addr >> 2);
        reg_sel  = counter_addr[1:0];
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Per-channel write decode; channels beyond CHANNELS never match.
        always_comb begin
            wr_ctrl[i]   = counter_we && (chan_sel == i) && (reg_sel == REG_CTRL);
            wr_load[i]   = counter_we && (chan_sel == i) && (reg_sel == REG_LOAD);
            wr_status[i] = counter_we && (chan_sel == i) && (reg_sel == REG_STATUS);
        end

        if (i == 0) begin : g_first
            assign ext_ticks[i] = 1'b0;
        end else begin : g_rest
            assign ext_ticks[i] = term_events[i-1];
        end

        counter_channel #(
            .WIDTH      (WIDTH),
            .PRESCALE_W (PRESCALE_W),
            .CHAIN_OK   (i > 0)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_ctrl    (wr_ctrl[i]),
            .wr_load    (wr_load[i]),
            .wr_status  (wr_status[i]),
            .wdata      (counter_val),
            .ext_tick   (ext_ticks[i]),
            .term_event (term_events[i]),
            .ctrl_word  (ctrl_words[i]),
            .load_val   (load_vals[i]),
            .count_val  (count_vals[i]),
            .pend       (pend[i]),
            .irq_en     (irq_en[i]),
            .tc         (counter_tc[i]),
            .sq         (counter_sq[i])
        );
    end

    // Read mux; unpopulated channels read as zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_sel == i) begin
                case (reg_sel)
                    REG_CTRL:   rd_next = ctrl_words[i];
                    REG_LOAD:   rd_next = 32'(load_vals[i]);
                    REG_COUNT:  rd_next = 32'(count_vals[i]);
                    REG_STATUS: rd_next = {31'd0, pend[i]};
                    default:    rd_next = '0;
                endcase
            end
        end
    end

    // Registered read data and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_rdata <= '0;
            counter_irq   <= 1'b0;
        end else begin
            counter_rdata <= rd_next;
            counter_irq   <= |(pend & irq_en);
        end
    end

endmodule

// File: tb/tb_multi_counter_dev_io.sv
// Self-checking bench for multi_counter_dev_io (CHANNELS=4, WIDTH=32,
// PRESCALE_W=8). A register-level behavioural model predicts rdata, irq, tc
// and sq every cycle; directed tests add hand-computed literal expectations.
module tb_multi_counter_dev_io;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          counter_we;
    logic [3:0]    counter_addr;
    logic [31:0]   counter_val;
    logic [31:0]   counter_rdata;
    logic          counter_irq;
    logic [CH-1:0] counter_tc;
    logic [CH-1:0] counter_sq;

    int n_checks = 0;
    int n_fail   = 0;
    logic run_checks = 1'b0;

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    multi_counter_dev_io #(
        .CHANNELS   (CH),
        .WIDTH      (32),
        .PRESCALE_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .counter_we    (counter_we),
        .counter_addr  (counter_addr),
        .counter_val   (counter_val),
        .counter_rdata (counter_rdata),
        .counter_irq   (counter_irq),
        .counter_tc    (counter_tc),
        .counter_sq    (counter_sq)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        en;
        logic [1:0]  mode;
        logic        irqen;
        logic        chain;
        logic [7:0]  ps;
        logic [7:0]  psc;
        logic [31:0] load;
        logic [31:0] cnt;
        logic        pend;
        logic        tc;
        logic        sq;
    } chan_t;
    typedef chan_t [CH-1:0] bank_t;

    bank_t       m_bank;
    logic        m_irq;
    logic [31:0] m_rdata;

    function automatic logic [31:0] model_read(input bank_t b, input logic [3:0] a);
        chan_t s;
        s = b[a[3:2]];
        case (a[1:0])
            2'd0:    return {16'd0, s.ps, 3'd0, s.chain, s.irqen, s.mode, s.en};
            2'd1:    return s.load;
            2'd2:    return s.cnt;
            default: return {31'd0, s.pend};
        endcase
    endfunction

    function automatic logic model_irq(input bank_t b);
        logic r;
        r = 1'b0;
        for (int c = 0; c < CH; c++) r = r | (b[c].pend & b[c].irqen);
        return r;
    endfunction

    function automatic bank_t model_step(input bank_t cur, input logic we,
                                         input logic [3:0] a, input logic [31:0] v);
        bank_t nx;
        chan_t s, n;
        logic  sel, w_ctrl, w_load, w_clr, own, src, tick, fire, fired_prev;
        nx = cur;
        fired_prev = 1'b0;
        for (int c = 0; c < CH; c++) begin
            s = cur[c];
            n = s;
            sel    = we && (int'(a[3:2]) == c);
            w_ctrl = sel && (a[1:0] == 2'd0);
            w_load = sel && (a[1:0] == 2'd1);
            w_clr  = sel && (a[1:0] == 2'd3) && v[0];
            own    = s.en && (s.psc == s.ps);
            src    = own;
`ifdef COUNTER_CHAIN_EN
            if (c > 0 && s.chain) src = fired_prev;
`endif
            tick = s.en && src && !w_ctrl && !w_load && (s.cnt != 0) && (s.load != 0);
            fire = tick && (s.cnt == 32'd1);
            if (w_ctrl || w_load) n.psc = 8'd0;
            else if (s.en)        n.psc = own ? 8'd0 : s.psc + 8'd1;
            n.tc = fire;
            if (fire) begin
                if (s.mode == 2'd1) n.cnt = s.load;
                else if (s.mode == 2'd2) begin
                    n.cnt = s.load;
                    n.sq  = ~s.sq;
                end else begin
                    n.cnt = 32'd0;
                    n.en  = 1'b0;
                end
            end else if (tick) begin
                n.cnt = s.cnt - 32'd1;
            end
            if (fire)       n.pend = 1'b1;
            else if (w_clr) n.pend = 1'b0;
            if (w_ctrl) begin
                n.en    = v[0];
                n.mode  = v[2:1];
                n.irqen = v[3];
`ifdef COUNTER_CHAIN_EN
                n.chain = v[4];
`endif
                n.ps    = v[15:8];
            end
            if (w_load) begin
                n.load = v;
                n.cnt  = v;
            end
            nx[c] = n;
            fired_prev = fire;
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bank  <= '0;
            m_irq   <= 1'b0;
            m_rdata <= '0;
        end else begin
            m_rdata <= model_read(m_bank, counter_addr);
            m_irq   <= model_irq(m_bank);
            m_bank  <= model_step(m_bank, counter_we, counter_addr, counter_val);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_checks && rst_n) begin
            logic [CH-1:0] e_tc, e_sq;
            for (int c = 0; c < CH; c++) begin
                e_tc[c] = m_bank[c].tc;
                e_sq[c] = m_bank[c].sq;
            end
            check("model_tc",    32'(counter_tc), 32'(e_tc));
            check("model_sq",    32'(counter_sq), 32'(e_sq));
            check("model_irq",   32'(counter_irq), 32'(m_irq));
            check("model_rdata", counter_rdata, m_rdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        counter_we   = 1'b1;
        counter_addr = a;
        counter_val  = v;
        @(posedge clk); #1;
        counter_we   = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        counter_addr = a;
        @(posedge clk); #1;
        d = counter_rdata;
    endtask

    // Edges until counter_tc[c] is seen high; -1 if the budget runs out.
    task automatic wait_tc(input int c, input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (counter_tc[c]) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_sq(input int c, input int budget, output int k);
        logic v0;
        v0 = counter_sq[c];
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (counter_sq[c] != v0) begin
                k = i;
                break;
            end
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] d;
        int k;
        rst_n        = 1'b0;
        counter_we   = 1'b0;
        counter_addr = 4'd0;
        counter_val  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", counter_rdata, 32'd0);
        check("rst_irq",   32'(counter_irq), 32'd0);
        check("rst_tc",    32'(counter_tc), 32'd0);
        check("rst_sq",    32'(counter_sq), 32'd0);
        rst_n      = 1'b1;
        run_checks = 1'b1;

        // 1: every register reads zero after reset
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), d);
            check("t1_reset_read", d, 32'd0);
        end
        check("t1_irq", 32'(counter_irq), 32'd0);

        // 2: ch0 periodic LOAD=5, prescale 0, irq enabled
        bus_write(4'd1, 32'd5);
        bus_write(4'd0, 32'h0000_000B);
        wait_tc(0, 20, k);
        check("t2_first_tc_delay", 32'(k), 32'd5);
        check("t2_irq_lag", 32'(counter_irq), 32'd0);
        @(posedge clk); #1;
        check("t2_irq_rise", 32'(counter_irq), 32'd1);
        bus_write(4'd3, 32'd1);
        check("t2_irq_hold", 32'(counter_irq), 32'd1);
        @(posedge clk); #1;
        check("t2_irq_drop", 32'(counter_irq), 32'd0);
        wait_tc(0, 20, k);
        check("t2_tc_next", 32'(k), 32'd1);
        wait_tc(0, 20, k);
        check("t2_tc_period", 32'(k), 32'd5);
        bus_write(4'd0, 32'd0);

        // 3: ch1 one-shot LOAD=3, prescale 3 -> single tc after 12 cycles
        bus_write(4'd5, 32'd3);
        bus_write(4'd4, 32'h0000_0301);
        wait_tc(1, 40, k);
        check("t3_tc_delay", 32'(k), 32'd12);
        bus_read(4'd6, d);
        check("t3_count_zero", d, 32'd0);
        bus_read(4'd4, d);
        check("t3_ctrl_disabled", d, 32'h0000_0300);
        wait_tc(1, 30, k);
        check("t3_no_retrigger", 32'(k), 32'hFFFF_FFFF);

        // 4: ch2 square LOAD=2, prescale 1 -> toggle every 4 cycles
        bus_write(4'd9, 32'd2);
        bus_write(4'd8, 32'h0000_0105);
        wait_sq(2, 20, k);
        check("t4_sq_first", 32'(k), 32'd4);
        check("t4_sq_high", 32'(counter_sq[2]), 32'd1);
        wait_sq(2, 20, k);
        check("t4_sq_half_period", 32'(k), 32'd4);
        check("t4_sq_low", 32'(counter_sq[2]), 32'd0);
        bus_write(4'd8, 32'd0);

        // 5: W1C colliding with a terminal event; LOAD colliding with a tick
        bus_write(4'd13, 32'd3);
        bus_write(4'd12, 32'h0000_0003);
        @(posedge clk);
        bus_write(4'd15, 32'd1);
        check("t5_tc_at_w1c", 32'(counter_tc[3]), 32'd1);
        bus_read(4'd15, d);
        check("t5_pend_set_wins", d, 32'd1);
        bus_write(4'd13, 32'd7);
        counter_addr = 4'd14;
        @(posedge clk); #1;
        check("t5_load_wins", counter_rdata, 32'd7);
        bus_write(4'd12, 32'd0);

`ifdef COUNTER_CHAIN_EN
        // 6: ch0 periodic LOAD=4 feeding ch1 chained LOAD=3 -> tc every 12
        bus_write(4'd5, 32'd3);
        bus_write(4'd4, 32'h0000_0013);
        bus_write(4'd1, 32'd4);
        bus_write(4'd0, 32'h0000_0003);
        wait_tc(1, 40, k);
        check("t6_chain_first", 32'(k), 32'd12);
        wait_tc(1, 40, k);
        check("t6_chain_period", 32'(k), 32'd12);
        bus_write(4'd0, 32'd0);
        bus_write(4'd4, 32'd0);
`else
        // 6: chain bit is read-as-zero without the feature
        bus_write(4'd4, 32'h0000_0010);
        bus_read(4'd4, d);
        check("t6_chain_ro", d, 32'd0);
`endif

        // 7: reset in the middle of a count
        bus_write(4'd9, 32'd2);
        bus_write(4'd8, 32'h0000_0105);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_tc",    32'(counter_tc), 32'd0);
        check("t7_rst_sq",    32'(counter_sq), 32'd0);
        check("t7_rst_rdata", counter_rdata, 32'd0);
        check("t7_rst_irq",   32'(counter_irq), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_read(4'd8, d);
        check("t7_ctrl_cleared", d, 32'd0);
        wait_tc(2, 20, k);
        check("t7_no_tc_after_reset", 32'(k), 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
